// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU and LSU result ports, issue-stage
// scoreboard query, and the register-file write port.
// master = producers / issue stage / regfile side, slave = the arbiter.
interface wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic [4:0]  wb_rd;
  logic [63:0] wb_out;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, lsu_ready, busy_rs1, busy_rs2, wb_rd, wb_out
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, lsu_ready, busy_rs1, busy_rs2, wb_rd, wb_out
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges fixed-latency ALU results and FIFO-buffered LSU load
// results into the single register-file write port (one write per cycle).
// The LSU FIFO head may lose to the ALU at most MAX_WAIT times in a row,
// after which it forces its slot and the ALU is stalled for that cycle.
// Optional feature: define WB_SCOREBOARD_EN to build the pending-register
// scoreboard used by the issue stage for RAW interlock; otherwise
// busy_rs1/busy_rs2 are tied low and the issue/query inputs are ignored.
module wb_arbiter #(
  parameter int LSU_DEPTH = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(LSU_DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  // FIFO storage (data only, never reset) and control pointers
  logic [4:0]    r_mem_rd   [LSU_DEPTH];
  logic [63:0]   r_mem_data [LSU_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [WW-1:0] r_wait;

  logic [4:0]    r_wb_rd;
  logic [63:0]   r_wb_out;

  logic          w_empty;
  logic          w_full;
  logic          w_force;
  logic          w_alu_win;
  logic          w_pop;
  logic          w_push;
  logic [4:0]    w_head_rd;
  logic [63:0]   w_head_data;
  logic [4:0]    w_win_rd;
  logic [63:0]   w_win_data;

  // Pointers carry one extra wrap bit: equal = empty, equal index with
  // differing wrap bit = full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_head_rd   = r_mem_rd[r_rd_ptr[AW-1:0]];
  assign w_head_data = r_mem_data[r_rd_ptr[AW-1:0]];

  // A starved head takes the slot unconditionally; the ALU must hold.
  assign w_force   = !w_empty && (r_wait == WAIT_MAX);
  assign w_alu_win = !w_force && bus.alu_valid && (bus.alu_rd != 5'd0);
  // Pop on force, or whenever the ALU has nothing real to write.
  assign w_pop     = !w_empty && !w_alu_win;
  // rd=0 loads are accepted but never stored.
  assign w_push    = bus.lsu_valid && !w_full && (bus.lsu_rd != 5'd0);

  assign w_win_rd   = w_alu_win ? bus.alu_rd   : (w_pop ? w_head_rd   : 5'd0);
  assign w_win_data = w_alu_win ? bus.alu_data : w_head_data;

  assign bus.alu_ready = !w_force;
  assign bus.lsu_ready = !w_full;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_out    = r_wb_out;

  // Write an accepted load into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr[AW-1:0]]   <= bus.lsu_rd;
      r_mem_data[r_wr_ptr[AW-1:0]] <= bus.lsu_data;
    end
  end

  // Advance FIFO pointers on push/pop; reset discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Count consecutive ALU wins over a waiting FIFO head, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_pop || w_empty) begin
      r_wait <= '0;
    end else if (w_alu_win && (r_wait != WAIT_MAX)) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  // Register the winning write; data holds when there is no winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_rd  <= 5'd0;
      r_wb_out <= 64'd0;
    end else begin
      r_wb_rd <= w_win_rd;
      if (w_win_rd != 5'd0) r_wb_out <= w_win_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:1] r_pending;
  logic [31:0] w_pend_full;

  // Track outstanding destinations; an issue in the same cycle as the
  // write-back of the same rd keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (bus.iss_valid && (bus.iss_rd == 5'(i)))
          r_pending[i] <= 1'b1;
        else if (w_win_rd == 5'(i))
          r_pending[i] <= 1'b0;
      end
    end
  end

  // x0 is never pending.
  assign w_pend_full  = {r_pending, 1'b0};
  assign bus.busy_rs1 = (bus.rs1 != 5'd0) && w_pend_full[bus.rs1];
  assign bus.busy_rs2 = (bus.rs2 != 5'd0) && w_pend_full[bus.rs2];
`else
  logic w_unused_sb;
  assign w_unused_sb  = ^{bus.iss_valid, bus.iss_rd, bus.rs1, bus.rs2};
  assign bus.busy_rs1 = 1'b0;
  assign bus.busy_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// with a queue-based reference model and a write-port scoreboard.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wb_arbiter_if bus ();

  wb_arbiter #(.LSU_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wb_t         exp_q[$];
  wb_t         fifo_m[$];
  int          wait_m = 0;
  bit          pend_m[32];
  bit          hold = 0;
  logic [4:0]  hold_rd = '0;
  logic [63:0] hold_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    fifo_m.delete();
    wait_m = 0;
    hold = 0;
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.iss_valid = 0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
  endtask

  // One clock cycle: apply inputs, check combinational outputs against the
  // model, then advance the model to the state after the next rising edge.
  task automatic step(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [63:0] ld,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    int  cnt;
    bit  e_lr, force_m, has, popped, alu_won;
    bit  e_b1, e_b2;
    wb_t w;
    @(negedge clk);
    #1;
    if (hold) begin
      av = 1; ard = hold_rd; ad = hold_data;
    end
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
    bus.iss_valid = iv; bus.iss_rd = ird; bus.rs1 = r1; bus.rs2 = r2;
    #1;
    cnt     = fifo_m.size();
    e_lr    = (cnt < DEPTH);
    force_m = (cnt > 0) && (wait_m == MAXW);
`ifdef WB_SCOREBOARD_EN
    e_b1 = (r1 != 0) && pend_m[int'(r1)];
    e_b2 = (r2 != 0) && pend_m[int'(r2)];
`else
    e_b1 = 0;
    e_b2 = 0;
`endif
    chk("lsu_ready", bus.lsu_ready, e_lr);
    chk("alu_ready", bus.alu_ready, !force_m);
    chk("busy_rs1", bus.busy_rs1, e_b1);
    chk("busy_rs2", bus.busy_rs2, e_b2);
    has = 0; popped = 0; alu_won = 0; w = '0;
    if (force_m) begin
      w = fifo_m.pop_front(); has = 1; popped = 1;
    end else if (av && ard != 0) begin
      w.rd = ard; w.data = ad; has = 1; alu_won = 1;
    end else if (cnt > 0) begin
      w = fifo_m.pop_front(); has = 1; popped = 1;
    end
    if (has) exp_q.push_back(w);
    if (lv && e_lr && lrd != 0) fifo_m.push_back('{rd: lrd, data: ld});
    if (popped || cnt == 0) wait_m = 0;
    else if (alu_won && wait_m < MAXW) wait_m++;
    if (has) pend_m[int'(w.rd)] = 0;
    if (iv && ird != 0) pend_m[int'(ird)] = 1;
    hold = av && force_m;
    hold_rd = ard;
    hold_data = ad;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of traffic; everything must clear.
  task automatic do_reset();
    @(negedge clk);
    #1;
    drive_idle();
    bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    rst_n = 0;
    #1;
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_out", bus.wb_out, 0);
    chk("rst_lsu_ready", bus.lsu_ready, 1);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_busy_rs1", bus.busy_rs1, 0);
    chk("rst_busy_rs2", bus.busy_rs2, 0);
    model_clear();
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  // Scoreboard: every real write must match the next expected write in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wb_rd !== 5'd0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no write at %0t",
                 bus.wb_rd, bus.wb_out, $time);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (bus.wb_rd !== e.rd || bus.wb_out !== e.data) begin
          bad++;
          $display("FAIL wb_write: got rd=%0d data=%0h expected rd=%0d data=%0h at %0t",
                   bus.wb_rd, bus.wb_out, e.rd, e.data, $time);
        end
      end
    end
  end

  initial begin
    int pa, pl;
    drive_idle();
    model_clear();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_wb_rd", bus.wb_rd, 0);
    chk("init_wb_out", bus.wb_out, 0);
    chk("init_lsu_ready", bus.lsu_ready, 1);
    rst_n = 1;

    // ALU only
    step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // LSU only
    step(0, 0, 0, 1, 7, 64'hAA, 0, 0, 0, 0);
    idle(3);
    // Fill the FIFO while the ALU wins every cycle, until the head is forced
    for (int i = 0; i < 14; i++)
      step(1, 1, 64'(100 + i), i < 4, 5'(10 + i), 64'(200 + i), 0, 0, 0, 0);
    idle(6);
    // ALU rd=0 alongside a waiting head; LSU rd=0 dropped
    step(1, 2, 64'h22, 1, 9, 64'h99, 0, 0, 0, 0);
    step(1, 0, 64'h55, 1, 0, 64'h77, 0, 0, 0, 0);
    idle(3);
    // Scoreboard: issue, write-back, same-cycle re-issue, x0 query
    step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    step(1, 3, 64'h333, 0, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    step(1, 3, 64'h334, 0, 0, 0, 1, 3, 3, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    idle(2);
    // Reset with three entries held in the FIFO
    for (int i = 0; i < 3; i++)
      step(1, 2, 64'(300 + i), 1, 5'(20 + i), 64'(400 + i), 1, 5'(20 + i), 0, 0);
    do_reset();
    idle(4);

    // Random traffic with varying load
    for (int blk = 0; blk < 12; blk++) begin
      pa = (blk % 3 == 0) ? 95 : 40 + (blk * 5);
      pl = (blk % 2 == 0) ? 60 : 25;
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < pa, 5'($urandom_range(0, 31)),
             {$urandom, $urandom},
             $urandom_range(0, 99) < pl, 5'($urandom_range(0, 31)),
             {$urandom, $urandom},
             $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      if (blk == 6) do_reset();
    end

    idle(40);
    chk("drain_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
